// File: rtl/fp32_seq_pkg.sv
// Shared constants and FSM state encoding for the FP32 multiplier sequencer.
// State codes are plain localparams so older tools and netlists see fixed encodings.
package fp32_seq_pkg;

    localparam int unsigned FP32_W = 32;

    typedef logic [2:0] seq_state_e;

    localparam seq_state_e IDLE  = 3'd0;
    localparam seq_state_e RD_A  = 3'd1;
    localparam seq_state_e RD_B  = 3'd2;
    localparam seq_state_e ISSUE = 3'd3;
    localparam seq_state_e DRAIN = 3'd4;

endpackage

// File: rtl/fp32_seq_result_stage.sv
// Result collection for the sequencer: one capture register, in-order result RAM writes,
// saturating overflow/underflow counters and spurious-done detection (FP32_SEQ_CHECK_EN adds compare).
module fp32_seq_result_stage
    import fp32_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              issue,
    input  logic              mul_done,
    input  logic [FP32_W-1:0] mul_result,
    input  logic              mul_overflow,
    input  logic              mul_underflow,
    output logic              res_wr_en,
    output logic [ADDR_W-1:0] res_wr_addr,
    output logic [FP32_W-1:0] res_wr_data,
    output logic [CNT_W-1:0]  rx_count,
    output logic [CNT_W-1:0]  ovf_count,
    output logic [CNT_W-1:0]  unf_count,
    output logic              err_spurious
`ifdef FP32_SEQ_CHECK_EN
    ,
    output logic [ADDR_W-1:0] exp_rd_addr,
    input  logic [FP32_W-1:0] exp_rd_data,
    output logic [CNT_W-1:0]  mismatch_count
`endif
);

    logic [CNT_W-1:0]  outstanding_q;
    logic [CNT_W-1:0]  rx_q;
    logic [CNT_W-1:0]  ovf_q;
    logic [CNT_W-1:0]  unf_q;
    logic [FP32_W-1:0] data_q;
    logic              wr_valid_q;
    logic              ovf_flag_q;
    logic              unf_flag_q;
    logic              err_q;
    logic              accept;

    // A done with nothing in flight is dropped and flagged instead of written.
    assign accept = mul_done && (outstanding_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= '0;
            rx_q          <= '0;
            ovf_q         <= '0;
            unf_q         <= '0;
            data_q        <= '0;
            wr_valid_q    <= 1'b0;
            ovf_flag_q    <= 1'b0;
            unf_flag_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            if (issue && !accept) begin
                outstanding_q <= outstanding_q + CNT_W'(1);
            end else if (!issue && accept) begin
                outstanding_q <= outstanding_q - CNT_W'(1);
            end

            if (mul_done && !accept) begin
                err_q <= 1'b1;
            end

            wr_valid_q <= accept;
            if (accept) begin
                data_q     <= mul_result;
                ovf_flag_q <= mul_overflow;
                unf_flag_q <= mul_underflow;
            end

            if (clear) begin
                rx_q  <= '0;
                ovf_q <= '0;
                unf_q <= '0;
            end else if (wr_valid_q) begin
                rx_q <= rx_q + CNT_W'(1);
                if (ovf_flag_q && (ovf_q != '1)) begin
                    ovf_q <= ovf_q + CNT_W'(1);
                end
                if (unf_flag_q && (unf_q != '1)) begin
                    unf_q <= unf_q + CNT_W'(1);
                end
            end
        end
    end

    assign res_wr_en    = wr_valid_q;
    assign res_wr_addr  = ADDR_W'(rx_q);
    assign res_wr_data  = data_q;
    assign rx_count     = rx_q;
    assign ovf_count    = ovf_q;
    assign unf_count    = unf_q;
    assign err_spurious = err_q;

`ifdef FP32_SEQ_CHECK_EN
    logic [CNT_W-1:0] mismatch_q;

    // Index of the result arriving now, allowing for a write still pending this cycle.
    assign exp_rd_addr = ADDR_W'(rx_q + CNT_W'(wr_valid_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_q <= '0;
        end else if (clear) begin
            mismatch_q <= '0;
        end else if (wr_valid_q && (data_q != exp_rd_data) && (mismatch_q != '1)) begin
            mismatch_q <= mismatch_q + CNT_W'(1);
        end
    end

    assign mismatch_count = mismatch_q;
`endif

endmodule

// File: rtl/fp32_mult_sequencer.sv
// Batch sequencer feeding operand pairs from RAM to the pipelined FP32 multiplier.
// Optional result checking is enabled by defining FP32_SEQ_CHECK_EN.
module fp32_mult_sequencer
    import fp32_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_go,
    input  logic [CNT_W-1:0]  cmd_pairs,
    output logic              busy,
    output logic              batch_done,
    output logic              op_rd_en,
    output logic [ADDR_W-1:0] op_rd_addr,
    input  logic [FP32_W-1:0] op_rd_data,
    output logic              mul_start,
    output logic [FP32_W-1:0] mul_a,
    output logic [FP32_W-1:0] mul_b,
    input  logic              mul_done,
    input  logic [FP32_W-1:0] mul_result,
    input  logic              mul_overflow,
    input  logic              mul_underflow,
    output logic              res_wr_en,
    output logic [ADDR_W-1:0] res_wr_addr,
    output logic [FP32_W-1:0] res_wr_data,
    output logic [CNT_W-1:0]  ovf_count,
    output logic [CNT_W-1:0]  unf_count,
    output logic              err_spurious
`ifdef FP32_SEQ_CHECK_EN
    ,
    output logic [ADDR_W-1:0] exp_rd_addr,
    input  logic [FP32_W-1:0] exp_rd_data,
    output logic [CNT_W-1:0]  mismatch_count
`endif
);

    seq_state_e        state_q;
    logic [CNT_W-1:0]  k_q;
    logic [CNT_W-1:0]  n_q;
    logic [FP32_W-1:0] a_q;
    logic [FP32_W-1:0] mul_a_q;
    logic [FP32_W-1:0] mul_b_q;
    logic [ADDR_W-1:0] addr_q;
    logic              busy_q;
    logic              done_q;
    logic              mul_start_q;
    logic              start_batch;
    logic [CNT_W-1:0]  rx_count;

    // Operand RAM layout: a_k at word 2k, b_k at word 2k+1.
    function automatic logic [ADDR_W-1:0] pair_addr(input logic [CNT_W-1:0] idx,
                                                    input logic odd);
        logic [CNT_W:0] word;
        word = {idx, odd};
        return ADDR_W'(word);
    endfunction

    assign start_batch = (state_q == IDLE) && cmd_go && (cmd_pairs != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            n_q         <= '0;
            a_q         <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mul_start_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            mul_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_go) begin
                        if (cmd_pairs != '0) begin
                            n_q     <= cmd_pairs;
                            k_q     <= '0;
                            addr_q  <= pair_addr('0, 1'b0);
                            busy_q  <= 1'b1;
                            state_q <= RD_A;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RD_A: begin
                    addr_q  <= pair_addr(k_q, 1'b1);
                    state_q <= RD_B;
                end
                RD_B: begin
                    a_q     <= op_rd_data;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    // b arrives this cycle; the pair is presented with mul_start next cycle.
                    mul_a_q     <= a_q;
                    mul_b_q     <= op_rd_data;
                    mul_start_q <= 1'b1;
                    k_q         <= k_q + CNT_W'(1);
                    if (k_q == n_q - CNT_W'(1)) begin
                        state_q <= DRAIN;
                    end else begin
                        addr_q  <= pair_addr(k_q + CNT_W'(1), 1'b0);
                        state_q <= RD_A;
                    end
                end
                DRAIN: begin
                    if ((rx_count == n_q) && !res_wr_en) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign batch_done = done_q;
    assign op_rd_en   = (state_q == RD_A) || (state_q == RD_B);
    assign op_rd_addr = addr_q;
    assign mul_start  = mul_start_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;

    fp32_seq_result_stage #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_result_stage (
        .clk            (clk),
        .rst            (rst),
        .clear          (start_batch),
        .issue          (mul_start_q),
        .mul_done       (mul_done),
        .mul_result     (mul_result),
        .mul_overflow   (mul_overflow),
        .mul_underflow  (mul_underflow),
        .res_wr_en      (res_wr_en),
        .res_wr_addr    (res_wr_addr),
        .res_wr_data    (res_wr_data),
        .rx_count       (rx_count),
        .ovf_count      (ovf_count),
        .unf_count      (unf_count),
        .err_spurious   (err_spurious)
`ifdef FP32_SEQ_CHECK_EN
        ,
        .exp_rd_addr    (exp_rd_addr),
        .exp_rd_data    (exp_rd_data),
        .mismatch_count (mismatch_count)
`endif
    );

endmodule
